// File: rtl/if_id_stage_reg.sv
// IF/ID stage register: PC/instruction with valid/ready, flush and stall counter.
// Define IF_ID_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module if_id_stage_reg #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PC_WIDTH-1:0]    main_pc_q;
  logic [INSTR_WIDTH-1:0] main_instr_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic accept;
  logic consume;
  logic go;
  logic stall;
  logic ld_main;
  logic ld_skid;
  logic skid2main;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign go        = !flush;
  assign stall     = out_valid && !out_ready && !flush;

  assign out_pc      = out_valid ? main_pc_q : '0;
  assign out_instr   = out_valid ? main_instr_q : NOP_INSTR;
  assign stall_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    skid2main = 1'b0;
    unique case (1'b1)
      flush: begin
        state_d = EMPTY;
      end
      go && (state_q == EMPTY) && accept: begin
        state_d = ONE;
        ld_main = 1'b1;
      end
      go && (state_q == ONE) && accept && consume: begin
        ld_main = 1'b1;
      end
`ifdef IF_ID_SKID_EN
      go && (state_q == ONE) && accept && !consume: begin
        state_d = TWO;
        ld_skid = 1'b1;
      end
      go && (state_q == TWO) && consume: begin
        state_d   = ONE;
        skid2main = 1'b1;
      end
`endif
      go && (state_q == ONE) && consume && !accept: begin
        state_d = EMPTY;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef IF_ID_SKID_EN
  logic [PC_WIDTH-1:0]    skid_pc_q;
  logic [INSTR_WIDTH-1:0] skid_instr_q;
  logic                   ready_q;

  // Ready is a pure flop so decode back-pressure never reaches fetch combinationally.
  assign in_ready = ready_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      if (ld_main) begin
        main_pc_q    <= in_pc;
        main_instr_q <= in_instr;
      end else if (skid2main) begin
        main_pc_q    <= skid_pc_q;
        main_instr_q <= skid_instr_q;
      end
      if (ld_skid) begin
        skid_pc_q    <= in_pc;
        skid_instr_q <= in_instr;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
    end else if (ld_main) begin
      main_pc_q    <= in_pc;
      main_instr_q <= in_instr;
    end
  end

  logic unused_skid;
  assign unused_skid = ld_skid | skid2main;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: queue-based reference model plus directed scenarios.
module tb_if_id_stage_reg;
  localparam int PW = 32;
  localparam int IW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pc = '0;
  logic [IW-1:0] in_instr = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic [CW-1:0] stall_count;

  if_id_stage_reg #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .NOP_INSTR(NOP), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t mq[$];
  logic m_ready = 1'b1;
  int   m_cnt = 0;
  logic m_v, m_acc, m_cons;

  function automatic logic exp_ready();
`ifdef IF_ID_SKID_EN
    return m_ready;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of depth 1 or 2 updated at each edge.
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      mq.delete();
      m_ready = 1'b1;
      m_cnt = 0;
    end else begin
      m_v    = (mq.size() != 0);
      m_acc  = in_valid && exp_ready();
      m_cons = m_v && out_ready;
      if (m_v && !out_ready && !flush && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_cons) void'(mq.pop_front());
        if (m_acc) mq.push_back({in_pc, in_instr});
      end
      m_ready = (mq.size() < 2);
    end
  end

  always @(negedge clock) begin
    chk("valid", out_valid, mq.size() != 0);
    chk("pc", out_pc, (mq.size() != 0) ? mq[0].pc : '0);
    chk("instr", out_instr, (mq.size() != 0) ? mq[0].instr : NOP);
    chk("in_ready", in_ready, exp_ready());
    chk("stall_count", stall_count, m_cnt);
  end

  task automatic cyc(input logic v, input logic [PW-1:0] pc,
                     input logic [IW-1:0] ins, input logic rdy,
                     input logic fl);
    @(posedge clock);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic neg();
    @(negedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 32'h13);
    chk("rst_cnt", stall_count, 0);
    chk("rst_ready", in_ready, 1);

    cyc(1, 32'h0, 32'h00500093, 1, 0);
    neg(); chk("pre_valid", out_valid, 0);
    cyc(1, 32'h4, 32'h00A00113, 1, 0);
    neg(); chk("s0_pc", out_pc, 32'h0);
    chk("s0_instr", out_instr, 32'h00500093);
    cyc(1, 32'h8, 32'h002081B3, 1, 0);
    neg(); chk("s1_pc", out_pc, 32'h4);
    chk("s1_instr", out_instr, 32'h00A00113);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("s2_pc", out_pc, 32'h8);
    chk("s2_instr", out_instr, 32'h002081B3);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("s3_valid", out_valid, 0);

`ifdef IF_ID_SKID_EN
    cyc(1, 32'h0, 32'h00500093, 0, 0);
    cyc(1, 32'h4, 32'h00A00113, 0, 0);
    neg(); chk("sk_ready1", in_ready, 1);
    cyc(0, 0, 0, 0, 0);
    neg(); chk("sk_ready0", in_ready, 0);
    chk("sk_hold_pc", out_pc, 32'h0);
    cyc(0, 0, 0, 0, 0);
    neg(); chk("sk_hold_pc2", out_pc, 32'h0);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("sk_rel_pc0", out_pc, 32'h0);
    chk("sk_cnt", stall_count, 3);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("sk_rel_pc4", out_pc, 32'h4);
    chk("sk_rel_instr4", out_instr, 32'h00A00113);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("sk_empty", out_valid, 0);
`else
    cyc(1, 32'h20, 32'h00500093, 0, 0);
    neg(); chk("ns_ready_empty", in_ready, 1);
    cyc(1, 32'h24, 32'h00A00113, 0, 0);
    neg(); chk("ns_ready_low", in_ready, 0);
    chk("ns_hold_pc", out_pc, 32'h20);
    cyc(1, 32'h24, 32'h00A00113, 1, 0);
    neg(); chk("ns_ready_high", in_ready, 1);
    cyc(0, 0, 0, 0, 0);
    neg(); chk("ns_pc24", out_pc, 32'h24);
    chk("ns_ready_low2", in_ready, 0);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("ns_ready_high2", in_ready, 1);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("ns_empty", out_valid, 0);
`endif

    cyc(1, 32'h40, 32'h00100093, 0, 0);
    cyc(1, 32'h10, 32'h00200093, 1, 1);
    neg(); chk("fl_ready", in_ready, 1);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("fl_valid", out_valid, 0);
    chk("fl_instr", out_instr, 32'h00000013);
    chk("fl_pc", out_pc, 0);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("fl_no10", out_valid, 0);

    cyc(1, 32'h60, 32'h00300093, 0, 0);
    cyc(1, 32'h64, 32'h00400093, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_instr", out_instr, NOP);
    chk("ar_cnt", stall_count, 0);
    chk("ar_ready", in_ready, 1);
    @(posedge clock);
    #1 reset = 1'b1;

    cyc(1, 32'h70, 32'h00500093, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);
    neg(); chk("sat15", stall_count, 15);
    repeat (3) cyc(0, 0, 0, 0, 0);
    neg(); chk("sat_hold", stall_count, 15);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    neg(); chk("sat_after", stall_count, 15);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
      end
    end

    cyc(0, 0, 0, 1, 0);
    repeat (3) @(posedge clock);
    neg();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage_reg.md
# if_id_stage_reg

Parametrised IF/ID pipeline stage register carrying PC and instruction from fetch to decode, with valid/ready flow control, flush (bubble insertion) and a stall-cycle counter. Replaces the fixed 32-bit, always-loading IF/ID latch, which has no back-pressure or flush. Sits between the instruction-memory output and the decoder. The hazard unit drives `out_ready` (decode stall) and `flush` (taken branch or jump).

## Interface
- `PC_WIDTH`, default 32: width of PC payload.
- `INSTR_WIDTH`, default 32: width of instruction payload.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `out_instr` while `out_valid`=0 (`addi x0,x0,0`).
- `CNT_WIDTH`, default 16: width of stall counter.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a PC/instruction pair.
- `in_ready`  out  1  stage accepts the pair this cycle.
- `in_pc`  in  PC_WIDTH  fetch PC.
- `in_instr`  in  INSTR_WIDTH  fetched instruction.
- `flush`  in  1  discard all held and incoming entries.
- `out_valid`  out  1  decode payload valid.
- `out_ready`  in  1  decode consumes the payload this cycle.
- `out_pc`  out  PC_WIDTH  head PC; 0 when `out_valid`=0.
- `out_instr`  out  INSTR_WIDTH  head instruction; `NOP_INSTR` when `out_valid`=0.
- `stall_count`  out  CNT_WIDTH  saturating count of back-pressured cycles.

## Operation
- Accept = `in_valid && in_ready`. Consume = `out_valid && out_ready`.
- Storage: main register (head) plus a skid register (see Configuration). Occupancy states: EMPTY, ONE, TWO. TWO exists only with skid.
- State transitions when `flush`=0:
  - EMPTY + accept -> ONE. Main <= input.
  - ONE + accept + consume -> ONE. Main <= input.
  - ONE + accept + no consume -> TWO. Skid <= input.
  - ONE + consume + no accept -> EMPTY.
  - TWO + consume -> ONE. Main <= skid. No accept is possible because `in_ready`=0.
  - Any other combination: hold.
- Flush:
  - `flush`=1 forces next state EMPTY, irrespective of consume.
  - A same-cycle accept is acknowledged via `in_ready` but dropped.
  - The payload is not cleared; the outputs are masked by `out_valid`.
- Stall counter:
  - +1 each cycle with `out_valid && !out_ready && !flush`.
  - Saturates at all-ones.
  - Cleared only by reset.
- Order preserved: strictly FIFO, no reordering, no duplication.

## Timing
- Reset (`reset`=0, asynchronous):
  - state EMPTY, `out_valid`=0, `out_pc`=0, `out_instr`=`NOP_INSTR`, `stall_count`=0.
  - `in_ready`=1 immediately after deassertion.
- Latency: accepted pair appears on outputs the next cycle.
- Throughput: 1 pair/cycle with `out_ready` held high.
- With skid:
  - `in_ready` is a register output = (next state != TWO).
  - No combinational path from `out_ready` to `in_ready`.
- Flush takes effect at the next edge: `out_valid`=0 the cycle after `flush` is asserted.
- Reset mid-transfer discards all entries. No partial payload is ever visible.

## Configuration
- `IF_ID_SKID_EN` defined:
  - 2-entry storage (main + skid).
  - Registered `in_ready`.
  - Full throughput with a fully registered ready path.
- Undefined:
  - Single entry; states EMPTY/ONE only.
  - `in_ready` = `!out_valid || out_ready` (combinational).
  - Skid register and TWO state absent.
  - All other behaviour identical.

## Test plan
- Reset then stream: pairs PC 0x0/0x4/0x8 with instr 0x00500093/0x00A00113/0x002081B3, `out_ready`=1 -> same pairs on outputs 1 cycle later, back-to-back. `out_valid` low the cycle before the first pair.
- Stall, skid build:
  - Setup: `IF_ID_SKID_EN` defined; 0x0 and 0x4 accepted; `out_ready`=0 for 3 cycles.
  - Response: `in_ready`=0 after the 2nd accept; 0x0 is held on the outputs.
  - Release: `out_ready`=1 -> 0x0 then 0x4; `stall_count`=3.
- Flush: ONE/TWO occupied, `flush`=1 coincident with a new accept (PC 0x10):
  - Next cycle `out_valid`=0, `out_instr`=0x00000013, `out_pc`=0.
  - PC 0x10 never appears.
- Async reset mid-stall:
  - Setup: `reset` low between edges while TWO.
  - Response: outputs go to reset values without a clock edge; `stall_count`=0.
- Counter saturation: `CNT_WIDTH`=4, held stall of 20 cycles -> `stall_count`=15 and it stays at 15.
- Without `IF_ID_SKID_EN`: `out_valid`=1, toggle `out_ready` -> `in_ready` follows `out_ready` in the same cycle. Ordering matches the first scenario.
